fp16_addsub_ctrl: RTL and testbench
===================================

FP16_ADDSUB_CTRL -- requirements
Module: fp16_addsub_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 START  input  1  request; sampled only in IDLE.
REQ-005 OP  input  1  0=A+B, 1=A-B (B sign inverted before processing).
REQ-006 IN_A  input  16  half-precision operand A {sign, exp[4:0], frac[9:0]}.
REQ-007 IN_B  input  16  half-precision operand B.
REQ-008 BUSY  output  1  high in every state except IDLE.
REQ-009 DONE  output  1  one-cycle pulse; Q/FLAGS valid from this cycle onward.
REQ-010 Q  output  16  result, held until the next DONE.
REQ-011 FLAGS  output  5  [4]=INVALID, [3]=reserved 0, [2]=UF, [1]=OF, [0]=INEXACT; held with Q.

Function
REQ-012 States SHALL be IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE.
REQ-013 IDLE: START=1 SHALL latch IN_A, IN_B, OP and go to UNPACK; START in any other state SHALL be ignored.
REQ-014 UNPACK: hidden bit=1 when exp!=0; exp=0 SHALL be treated as subnormal (hidden 0, effective exp 1); the larger-magnitude operand becomes "big"; d=exp_big-exp_small.
REQ-015 UNPACK special path: NaN or Inf operand, or Inf-Inf of opposite effective sign, SHALL go directly to DONE (latency 2).
REQ-016 Special results: any NaN or Inf-Inf -> Q=0x7E00, INVALID=1; a single Inf or Inf+Inf of same sign -> that Inf, flags 0.
REQ-017 Working mantissa SHALL be 15 bits: carry, hidden, 10 frac, guard, round, sticky.
REQ-018 ALIGN: the small mantissa SHALL shift right one bit per cycle for min(d,14) cycles, ORing shifted-out bits into sticky; d=0 skips ALIGN.
REQ-019 ADD: equal effective signs -> add; otherwise subtract small from big; sign = sign of big; exactly equal magnitudes -> +0.
REQ-020 NORM: carry set -> one right shift (sticky kept), exp+1; else left shift one bit per cycle while hidden=0 and exp>1; zero mantissa -> 0 NORM cycles.
REQ-021 ROUND: round-to-nearest-even on guard/round/sticky; mantissa rounding carry SHALL renormalize and increment exp in the same cycle.
REQ-022 INEXACT SHALL be the OR of guard, round and sticky before rounding.
REQ-023 Exp reaching 31 SHALL produce signed Inf with OF=1, INEXACT=1.
REQ-024 Subnormal (hidden=0) and inexact result SHALL set UF=1; exact subnormal SHALL leave UF=0.
REQ-025 DONE: Q/FLAGS registered, DONE=1 for one cycle, next state IDLE; START is not accepted in the DONE cycle.
REQ-026 Normal-path latency START-edge to DONE SHALL be 4+min(d,14)+k cycles, k = NORM cycles.

Reset
REQ-027 RST_N=0 SHALL asynchronously force IDLE, BUSY=0, DONE=0, Q=0x0000, FLAGS=0, clearing all working registers.
REQ-028 Reset mid-operation SHALL discard the operation with no DONE pulse; the first START after release is accepted normally.

Verification
REQ-029 0x3C00+0x3C00, OP=0 -> Q=0x4000, FLAGS=00000, DONE 5 cycles after START.
REQ-030 0x3C00, 0x3C00, OP=1 -> Q=0x0000, FLAGS=00000, DONE after 4 cycles.
REQ-031 0x7BFF+0x7BFF -> Q=0x7C00, FLAGS=00011.
REQ-032 0x7C00+0xFC00 -> Q=0x7E00, FLAGS=10000, DONE after 2 cycles.
REQ-033 0x3C00+0x0001 -> d=14, Q=0x3C00, FLAGS=00001, DONE after 18 cycles; START pulsed while BUSY is ignored.
REQ-034 RST_N low during ALIGN -> BUSY=0, DONE=0, Q=0x0000 immediately; no DONE follows; a new START completes normally.

Source files
------------

// File: rtl/fp16_addsub_ctrl.sv
// rtl/fp16_addsub_ctrl.sv - multi-cycle half-precision adder/subtractor with shift-per-cycle align and normalize
module fp16_addsub_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] q,
    output logic [4:0]  flags
);

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, q_q, q_d;
    logic        op_q, op_d, sign_q, sign_d, sub_q, sub_d;
    logic [5:0]  exp_q, exp_d;
    logic [14:0] mb_q, mb_d, ms_q, ms_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [4:0]  flags_q, flags_d;

    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, a_big;
    logic [4:0]  ea, eb, ea_eff, eb_eff, e_big, e_sm, d;
    logic [14:0] ma, mbv, add_sum;
    logic        rnd_up, r_hid, inexact;
    logic [11:0] rsum;
    logic [5:0]  r_exp;
    logic [9:0]  r_frac;

    assign sa     = a_q[15];
    assign sb     = b_q[15] ^ op_q;
    assign ea     = a_q[14:10];
    assign eb     = b_q[14:10];
    assign a_nan  = (&ea) & (|a_q[9:0]);
    assign b_nan  = (&eb) & (|b_q[9:0]);
    assign a_inf  = (&ea) & ~(|a_q[9:0]);
    assign b_inf  = (&eb) & ~(|b_q[9:0]);
    assign a_big  = a_q[14:0] >= b_q[14:0];
    assign ea_eff = (ea == 5'd0) ? 5'd1 : ea;
    assign eb_eff = (eb == 5'd0) ? 5'd1 : eb;
    assign ma     = {1'b0, |ea, a_q[9:0], 3'b000};
    assign mbv    = {1'b0, |eb, b_q[9:0], 3'b000};
    assign e_big  = a_big ? ea_eff : eb_eff;
    assign e_sm   = a_big ? eb_eff : ea_eff;
    assign d      = e_big - e_sm;

    assign add_sum = sub_q ? (mb_q - ms_q) : (mb_q + ms_q);

    // Rounding carry out of the 11-bit significand renormalizes in the same cycle.
    assign rnd_up  = mb_q[2] & (mb_q[1] | mb_q[0] | mb_q[3]);
    assign rsum    = {1'b0, mb_q[13:3]} + {11'd0, rnd_up};
    assign r_exp   = exp_q + {5'd0, rsum[11]};
    assign r_hid   = rsum[11] | rsum[10];
    assign r_frac  = rsum[11] ? rsum[10:1] : rsum[9:0];
    assign inexact = |mb_q[2:0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        sign_d  = sign_q;
        sub_d   = sub_q;
        exp_d   = exp_q;
        mb_d    = mb_q;
        ms_d    = ms_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    op_d    = op;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
                    q_d     = 16'h7E00;
                    flags_d = 5'b10000;
                    state_d = S_DONE;
                end else if (a_inf || b_inf) begin
                    q_d     = {a_inf ? sa : sb, 5'h1F, 10'd0};
                    flags_d = 5'b00000;
                    state_d = S_DONE;
                end else begin
                    sign_d  = a_big ? sa : sb;
                    sub_d   = sa ^ sb;
                    exp_d   = {1'b0, e_big};
                    mb_d    = a_big ? ma : mbv;
                    ms_d    = a_big ? mbv : ma;
                    cnt_d   = (d > 5'd14) ? 4'd14 : d[3:0];
                    state_d = (d == 5'd0) ? S_ADD : S_ALIGN;
                end
            end
            S_ALIGN: begin
                ms_d  = {1'b0, ms_q[14:2], ms_q[1] | ms_q[0]};
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                mb_d = add_sum;
                if (sub_q && (add_sum == 15'd0)) begin
                    sign_d = 1'b0;
                end
                if (add_sum[14] || ((add_sum != 15'd0) && !add_sum[13] && (exp_q > 6'd1))) begin
                    state_d = S_NORM;
                end else begin
                    state_d = S_ROUND;
                end
            end
            S_NORM: begin
                if (mb_q[14]) begin
                    mb_d    = {1'b0, mb_q[14:2], mb_q[1] | mb_q[0]};
                    exp_d   = exp_q + 6'd1;
                    state_d = S_ROUND;
                end else begin
                    mb_d    = {mb_q[13:0], 1'b0};
                    exp_d   = exp_q - 6'd1;
                    state_d = (!mb_q[12] && (exp_q > 6'd2)) ? S_NORM : S_ROUND;
                end
            end
            S_ROUND: begin
                if (r_exp >= 6'd31) begin
                    q_d     = {sign_q, 5'h1F, 10'd0};
                    flags_d = 5'b00011;
                end else begin
                    q_d     = {sign_q, r_hid ? r_exp[4:0] : 5'd0, r_frac};
                    flags_d = {2'b00, ~mb_q[13] & inexact, 1'b0, inexact};
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= 16'd0;
            b_q     <= 16'd0;
            op_q    <= 1'b0;
            sign_q  <= 1'b0;
            sub_q   <= 1'b0;
            exp_q   <= 6'd0;
            mb_q    <= 15'd0;
            ms_q    <= 15'd0;
            cnt_q   <= 4'd0;
            q_q     <= 16'd0;
            flags_q <= 5'd0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
            sub_q   <= sub_d;
            exp_q   <= exp_d;
            mb_q    <= mb_d;
            ms_q    <= ms_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            flags_q <= flags_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign q     = q_q;
    assign flags = flags_q;

endmodule

// File: tb/tb_fp16_addsub_ctrl.sv
// tb/tb_fp16_addsub_ctrl.sv - randomized self-checking bench for fp16_addsub_ctrl against an exact-arithmetic model
module tb_fp16_addsub_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [15:0] in_a = 16'd0;
    logic [15:0] in_b = 16'd0;
    logic        busy, done;
    logic [15:0] q;
    logic [4:0]  flags;

    fp16_addsub_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .in_a  (in_a),
        .in_b  (in_b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .flags (flags)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        pending = 1'b0;
    logic [15:0] exp_qv = 16'd0, hold_q = 16'd0;
    logic [4:0]  exp_fl = 5'd0, hold_fl = 5'd0;
    int          exp_lat = 0;
    int          s_edge = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Exact result in units of 2^-24, rounded to nearest-even; latency from value thresholds.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic o,
                                  output logic [15:0] rq, output logic [4:0] rf, output int lat);
        logic   sa, sb, s, up;
        int     ea, eb, fa, fb, xa, xb, e_big, d, k, e;
        longint va, vb, sum, mag, m, rem, half;
        sa = a[15]; sb = b[15] ^ o;
        ea = int'(a[14:10]); eb = int'(b[14:10]);
        fa = int'(a[9:0]);   fb = int'(b[9:0]);
        if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0) || (ea == 31 && eb == 31 && sa != sb)) begin
            rq = 16'h7E00; rf = 5'b10000; lat = 2; return;
        end
        if (ea == 31) begin rq = {sa, 15'h7C00}; rf = 5'b0; lat = 2; return; end
        if (eb == 31) begin rq = {sb, 15'h7C00}; rf = 5'b0; lat = 2; return; end
        xa = (ea == 0) ? 1 : ea;
        xb = (eb == 0) ? 1 : eb;
        va = (ea == 0) ? longint'(fa) : (longint'(1024 + fa) << (ea - 1));
        vb = (eb == 0) ? longint'(fb) : (longint'(1024 + fb) << (eb - 1));
        sum = (sa ? -va : va) + (sb ? -vb : vb);
        if (sum == 0) s = (sa == sb) ? sa : 1'b0;
        else          s = (sum < 0);
        mag = (sum < 0) ? -sum : sum;
        e_big = (a[14:0] >= b[14:0]) ? xa : xb;
        d = (xa > xb) ? xa - xb : xb - xa;
        k = 0;
        if (mag >= (longint'(1) << (e_big + 10))) k = 1;
        else if (mag != 0) begin
            e = e_big;
            while (e > 1 && mag < (longint'(1) << (e + 9))) begin e--; k++; end
        end
        lat = 4 + ((d > 14) ? 14 : d) + k;
        if (mag < 1024) begin rq = {s, 5'd0, mag[9:0]}; rf = 5'b0; return; end
        e = 1;
        while (mag >= (longint'(1) << (e + 10))) e++;
        m    = mag >> (e - 1);
        rem  = mag - (m << (e - 1));
        half = (e >= 2) ? (longint'(1) << (e - 2)) : 0;
        up   = (rem > half) || (rem == half && rem != 0 && m[0]);
        m    = m + longint'(up);
        if (m == 2048) begin m = 1024; e++; end
        if (e >= 31) begin rq = {s, 15'h7C00}; rf = 5'b00011; end
        else begin rq = {s, 5'(e), m[9:0]}; rf = {4'b0000, rem != 0}; end
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("busy", busy, pending && (cyc >= s_edge));
            if (done) begin
                check("done_expected", pending, 1);
                if (pending) begin
                    check("q", q, exp_qv);
                    check("flags", flags, exp_fl);
                    check("latency", cyc - s_edge + 1, exp_lat);
                    hold_q  = exp_qv;
                    hold_fl = exp_fl;
                    pending = 1'b0;
                end
            end else begin
                check("q_hold", q, hold_q);
                check("flags_hold", flags, hold_fl);
            end
        end
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic o, input int noise_at);
        @(posedge clk); #2;
        model(a, b, o, exp_qv, exp_fl, exp_lat);
        in_a = a; in_b = b; op = o; start = 1'b1;
        s_edge = cyc + 1;
        pending = 1'b1;
        for (int i = 1; i <= 40 && pending; i++) begin
            @(posedge clk); #2;
            start = (i == noise_at);
            if (i == noise_at) begin
                in_a = 16'($urandom); in_b = 16'($urandom); op = 1'($urandom);
            end
        end
        start = 1'b0;
        check("timeout", pending, 0);
        pending = 1'b0;
    endtask

    function automatic logic [15:0] rand_operand();
        int c;
        c = int'($urandom_range(0, 9));
        if (c == 0) return 16'($urandom);
        if (c == 1) return {1'($urandom), 5'h1F, ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom)};
        if (c == 2) return {1'($urandom), 5'd0, 10'($urandom)};
        return {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
    endfunction

    logic [15:0] pq, ra, rb;
    logic [4:0]  pf;
    int          pl;

    initial begin
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", q, 16'h0000);
        check("rst_flags", flags, 5'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        model(16'h3C00, 16'h3C00, 1'b0, pq, pf, pl);
        check("pin1_q", pq, 16'h4000); check("pin1_f", pf, 0); check("pin1_lat", pl, 5);
        model(16'h3C00, 16'h3C00, 1'b1, pq, pf, pl);
        check("pin2_q", pq, 16'h0000); check("pin2_f", pf, 0); check("pin2_lat", pl, 4);
        model(16'h7BFF, 16'h7BFF, 1'b0, pq, pf, pl);
        check("pin3_q", pq, 16'h7C00); check("pin3_f", pf, 5'b00011);
        model(16'h7C00, 16'hFC00, 1'b0, pq, pf, pl);
        check("pin4_q", pq, 16'h7E00); check("pin4_f", pf, 5'b10000); check("pin4_lat", pl, 2);
        model(16'h3C00, 16'h0001, 1'b0, pq, pf, pl);
        check("pin5_q", pq, 16'h3C00); check("pin5_f", pf, 5'b00001); check("pin5_lat", pl, 18);

        run_op(16'h3C00, 16'h3C00, 1'b0, 0);
        run_op(16'h3C00, 16'h3C00, 1'b1, 0);
        run_op(16'h7BFF, 16'h7BFF, 1'b0, 0);
        run_op(16'h7C00, 16'hFC00, 1'b0, 0);
        run_op(16'h3C00, 16'h0001, 1'b0, 5);

        // Reset while aligning: outputs clear at once, no completion follows.
        @(posedge clk); #2;
        in_a = 16'h3C00; in_b = 16'h0001; op = 1'b0; start = 1'b1;
        model(in_a, in_b, op, exp_qv, exp_fl, exp_lat);
        s_edge = cyc + 1; pending = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0; pending = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_q", q, 16'h0000);
        check("midrst_flags", flags, 5'd0);
        hold_q = 16'd0; hold_fl = 5'd0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (25) @(posedge clk);
        run_op(16'h4000, 16'h3C00, 1'b1, 0);

        for (int n = 0; n < 400; n++) begin
            ra = rand_operand();
            if ($urandom_range(0, 3) == 0) rb = ra ^ 16'($urandom_range(0, 7));
            else                           rb = rand_operand();
            run_op(ra, rb, 1'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
